uart_rxfifo_ctl: RTL and testbench

Receive-side buffer and status block placed directly downstream of the UART RX FSM. It accepts the FSM's one-cycle byte write strobes, stores bytes in a synchronous FIFO and returns `fifo_aval` back-pressure to the FSM. It also decodes the FSM's `error_ind` code into sticky, write-1-to-clear error flags and generates threshold and idle-timeout interrupt levels for the register block. Integration delivers the FSM strobes into `app_clk` as single-cycle pulses.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_sync_fifo.sv | 79 +++++++
 rtl/uart_rxfifo_ctl.sv | 106 ++++++++++
 tb/tb_uart_rxfifo_ctl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared codes and status bit indices for the UART receive path
package uart_pkg;

  localparam logic [1:0] UART_ERR_NONE = 2'b00;
  localparam logic [1:0] UART_ERR_FRM  = 2'b01;
  localparam logic [1:0] UART_ERR_PAR  = 2'b10;
  localparam logic [1:0] UART_ERR_FULL = 2'b11;

  localparam int STS_FRM = 0;
  localparam int STS_PAR = 1;
  localparam int STS_OVF = 2;

  // Maps an RX FSM error code onto the one-hot sticky status vector {ovf, par, frm}.
  function automatic logic [2:0] err_decode(input logic [1:0] code);
    logic [2:0] v;
    v = 3'b000;
    case (code)
      UART_ERR_FRM:  v[STS_FRM] = 1'b1;
      UART_ERR_PAR:  v[STS_PAR] = 1'b1;
      UART_ERR_FULL: v[STS_OVF] = 1'b1;
      UART_ERR_NONE: v = 3'b000;
      default:       v = 3'b000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - show-ahead synchronous FIFO with occupancy count
// Full writes and empty reads are refused here; the caller sees the accept strobes.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full,
  output logic [AW:0]      o_count,
  output logic             o_wr_acc,
  output logic             o_rd_acc
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  assign w_wr_acc = i_enable && i_wr && !w_full;
  assign w_rd_acc = i_enable && i_rd && !w_empty;

  // Array is deliberately left out of reset; only the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (!i_enable) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata  = r_mem[r_rd_ptr];
  assign o_empty  = w_empty;
  assign o_full   = w_full;
  assign o_count  = r_count;
  assign o_wr_acc = w_wr_acc;
  assign o_rd_acc = w_rd_acc;

endmodule

// File: rtl/uart_rxfifo_ctl.sv
// rtl/uart_rxfifo_ctl.sv - UART RX byte buffer with sticky error flags and interrupts
// Sits between the RX FSM and the register block in the app_clk domain.
module uart_rxfifo_ctl
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TW    = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          i_app_clk,
  input  logic          i_reset,
  input  logic          i_cfg_rx_enable,
  input  logic [AW:0]   i_cfg_rx_thresh,
  input  logic [TW-1:0] i_cfg_tout_val,
  input  logic          i_fifo_wr,
  input  logic [7:0]    i_fifo_data,
  input  logic [1:0]    i_error_ind,
  output logic          o_fifo_aval,
  input  logic          i_rd_en,
  output logic [7:0]    o_rd_data,
  output logic          o_rd_empty,
  output logic [AW:0]   o_rx_count,
  input  logic [2:0]    i_sts_clr,
  output logic          o_sts_frm_err,
  output logic          o_sts_par_err,
  output logic          o_sts_ovf,
  output logic          o_irq_thresh,
  output logic          o_irq_tout
);

  logic          w_empty;
  logic          w_full;
  logic [AW:0]   w_count;
  logic          w_wr_acc;
  logic          w_rd_acc;
  logic          w_wr_drop;
  logic [2:0]    w_sts_set;

  logic [1:0]    r_err_prev;
  logic [2:0]    r_sts;
  logic [TW-1:0] r_tout_cnt;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .i_clk    (i_app_clk),
    .i_rst    (i_reset),
    .i_enable (i_cfg_rx_enable),
    .i_wr     (i_fifo_wr),
    .i_wdata  (i_fifo_data),
    .i_rd     (i_rd_en),
    .o_rdata  (o_rd_data),
    .o_empty  (w_empty),
    .o_full   (w_full),
    .o_count  (w_count),
    .o_wr_acc (w_wr_acc),
    .o_rd_acc (w_rd_acc)
  );

  // A write refused for lack of space is an overflow; writes while disabled are simply ignored.
  assign w_wr_drop = i_cfg_rx_enable && i_fifo_wr && w_full;

  always_comb begin
    w_sts_set = 3'b000;
    if (i_error_ind != r_err_prev) begin
      w_sts_set = err_decode(i_error_ind);
    end
    if (w_wr_drop) begin
      w_sts_set[STS_OVF] = 1'b1;
    end
  end

  // Set beats clear so an event coinciding with a W1C write is never lost.
  always_ff @(posedge i_app_clk or posedge i_reset) begin
    if (i_reset) begin
      r_err_prev <= UART_ERR_NONE;
      r_sts      <= 3'b000;
    end else begin
      r_err_prev <= i_error_ind;
      r_sts      <= (r_sts & ~i_sts_clr) | w_sts_set;
    end
  end

  always_ff @(posedge i_app_clk or posedge i_reset) begin
    if (i_reset) begin
      r_tout_cnt <= '0;
    end else if (!i_cfg_rx_enable || w_wr_acc || w_rd_acc || w_empty || (i_cfg_tout_val == '0)) begin
      r_tout_cnt <= '0;
    end else if (r_tout_cnt >= i_cfg_tout_val) begin
      r_tout_cnt <= i_cfg_tout_val;
    end else begin
      r_tout_cnt <= r_tout_cnt + 1'b1;
    end
  end

  assign o_fifo_aval   = !w_full;
  assign o_rd_empty    = w_empty;
  assign o_rx_count    = w_count;
  assign o_sts_frm_err = r_sts[STS_FRM];
  assign o_sts_par_err = r_sts[STS_PAR];
  assign o_sts_ovf     = r_sts[STS_OVF];
  assign o_irq_thresh  = (i_cfg_rx_thresh != '0) && (w_count >= i_cfg_rx_thresh);
  assign o_irq_tout    = (r_tout_cnt == i_cfg_tout_val) && (i_cfg_tout_val != '0) && !w_empty;

endmodule

// File: tb/tb_uart_rxfifo_ctl.sv
// tb/tb_uart_rxfifo_ctl.sv - directed, table-driven bench for uart_rxfifo_ctl
module tb_uart_rxfifo_ctl;

  localparam int DEPTH = 16;
  localparam int TW    = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_rx_enable;
  logic [AW:0]   cfg_rx_thresh;
  logic [TW-1:0] cfg_tout_val;
  logic          fifo_wr;
  logic [7:0]    fifo_data;
  logic [1:0]    error_ind;
  logic          fifo_aval;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          rd_empty;
  logic [AW:0]   rx_count;
  logic [2:0]    sts_clr;
  logic          sts_frm_err;
  logic          sts_par_err;
  logic          sts_ovf;
  logic          irq_thresh;
  logic          irq_tout;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_rxfifo_ctl #(.DEPTH(DEPTH), .TW(TW)) dut (
    .i_app_clk       (clk),
    .i_reset         (reset),
    .i_cfg_rx_enable (cfg_rx_enable),
    .i_cfg_rx_thresh (cfg_rx_thresh),
    .i_cfg_tout_val  (cfg_tout_val),
    .i_fifo_wr       (fifo_wr),
    .i_fifo_data     (fifo_data),
    .i_error_ind     (error_ind),
    .o_fifo_aval     (fifo_aval),
    .i_rd_en         (rd_en),
    .o_rd_data       (rd_data),
    .o_rd_empty      (rd_empty),
    .o_rx_count      (rx_count),
    .i_sts_clr       (sts_clr),
    .o_sts_frm_err   (sts_frm_err),
    .o_sts_par_err   (sts_par_err),
    .o_sts_ovf       (sts_ovf),
    .o_irq_thresh    (irq_thresh),
    .o_irq_tout      (irq_tout)
  );

  typedef struct {
    logic       wr;
    logic [7:0] wdata;
    logic       rd;
    logic [1:0] err;
    logic [2:0] clr;
    logic [4:0] thresh;
    logic [4:0] e_count;
    logic [7:0] e_rdata;
    logic       e_empty;
    logic       e_aval;
    logic [2:0] e_sts;
    logic       e_irq;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] sts_vec();
    return {sts_ovf, sts_par_err, sts_frm_err};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    // {wr, wdata, rd, err, clr, thresh} -> {count, rd_data, empty, aval, {ovf,par,frm}, irq_thresh}
    // Starts from a full FIFO holding 0x00..0x0F.
    tbl[0]  = '{1'b1, 8'hAA, 1'b0, 2'b00, 3'b000, 5'd0,  5'd16, 8'h00, 1'b0, 1'b0, 3'b100, 1'b0};
    tbl[1]  = '{1'b1, 8'hBB, 1'b1, 2'b00, 3'b000, 5'd0,  5'd15, 8'h01, 1'b0, 1'b1, 3'b100, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 2'b00, 3'b100, 5'd0,  5'd15, 8'h01, 1'b0, 1'b1, 3'b000, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 2'b00, 3'b000, 5'd0,  5'd14, 8'h02, 1'b0, 1'b1, 3'b000, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 2'b01, 3'b000, 5'd0,  5'd14, 8'h02, 1'b0, 1'b1, 3'b001, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 2'b01, 3'b000, 5'd0,  5'd14, 8'h02, 1'b0, 1'b1, 3'b001, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 2'b01, 3'b001, 5'd0,  5'd14, 8'h02, 1'b0, 1'b1, 3'b000, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 2'b01, 3'b000, 5'd0,  5'd14, 8'h02, 1'b0, 1'b1, 3'b000, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 2'b01, 3'b000, 5'd0,  5'd14, 8'h02, 1'b0, 1'b1, 3'b000, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 2'b00, 3'b000, 5'd0,  5'd14, 8'h02, 1'b0, 1'b1, 3'b000, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 2'b01, 3'b001, 5'd0,  5'd14, 8'h02, 1'b0, 1'b1, 3'b001, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 2'b00, 3'b000, 5'd0,  5'd14, 8'h02, 1'b0, 1'b1, 3'b001, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 2'b10, 3'b000, 5'd0,  5'd14, 8'h02, 1'b0, 1'b1, 3'b011, 1'b0};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 2'b11, 3'b000, 5'd0,  5'd14, 8'h02, 1'b0, 1'b1, 3'b111, 1'b0};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 2'b00, 3'b111, 5'd0,  5'd14, 8'h02, 1'b0, 1'b1, 3'b000, 1'b0};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 2'b00, 3'b000, 5'd15, 5'd14, 8'h02, 1'b0, 1'b1, 3'b000, 1'b0};
    tbl[16] = '{1'b1, 8'hCC, 1'b0, 2'b00, 3'b000, 5'd15, 5'd15, 8'h02, 1'b0, 1'b1, 3'b000, 1'b1};
    tbl[17] = '{1'b0, 8'h00, 1'b1, 2'b00, 3'b000, 5'd15, 5'd14, 8'h03, 1'b0, 1'b1, 3'b000, 1'b0};

    reset         = 1'b1;
    cfg_rx_enable = 1'b1;
    cfg_rx_thresh = '0;
    cfg_tout_val  = '0;
    fifo_wr       = 1'b0;
    fifo_data     = 8'h00;
    error_ind     = 2'b00;
    rd_en         = 1'b0;
    sts_clr       = 3'b000;
    step();
    step();
    reset = 1'b0;

    chk("reset rd_empty", rd_empty, 1);
    chk("reset fifo_aval", fifo_aval, 1);
    chk("reset rx_count", rx_count, 0);
    chk("reset sts", sts_vec(), 0);
    chk("reset irq_thresh", irq_thresh, 0);
    chk("reset irq_tout", irq_tout, 0);

    // Fill
    for (int i = 0; i < DEPTH; i++) begin
      fifo_wr   = 1'b1;
      fifo_data = 8'(i);
      step();
      chk($sformatf("fill%0d rx_count", i), rx_count, i + 1);
      chk($sformatf("fill%0d fifo_aval", i), fifo_aval, (i == DEPTH - 1) ? 0 : 1);
    end
    fifo_wr = 1'b0;
    chk("fill rd_data head", rd_data, 8'h00);
    chk("fill rd_empty", rd_empty, 0);

    // Table-driven overflow / error decode / threshold vectors
    for (int v = 0; v < 18; v++) begin
      fifo_wr       = tbl[v].wr;
      fifo_data     = tbl[v].wdata;
      rd_en         = tbl[v].rd;
      error_ind     = tbl[v].err;
      sts_clr       = tbl[v].clr;
      cfg_rx_thresh = tbl[v].thresh;
      step();
      chk($sformatf("vec%0d rx_count", v), rx_count, tbl[v].e_count);
      chk($sformatf("vec%0d rd_data", v), rd_data, tbl[v].e_rdata);
      chk($sformatf("vec%0d rd_empty", v), rd_empty, tbl[v].e_empty);
      chk($sformatf("vec%0d fifo_aval", v), fifo_aval, tbl[v].e_aval);
      chk($sformatf("vec%0d sts", v), sts_vec(), tbl[v].e_sts);
      chk($sformatf("vec%0d irq_thresh", v), irq_thresh, tbl[v].e_irq);
    end
    fifo_wr       = 1'b0;
    rd_en         = 1'b0;
    error_ind     = 2'b00;
    sts_clr       = 3'b000;
    cfg_rx_thresh = '0;

    // Drain across the pointer wrap: 0x03..0x0F then 0xCC
    for (int i = 3; i < DEPTH; i++) begin
      chk($sformatf("drain%0d rd_data", i), rd_data, i);
      rd_en = 1'b1;
      step();
    end
    chk("drain wrapped rd_data", rd_data, 8'hCC);
    step();
    rd_en = 1'b0;
    chk("drain rd_empty", rd_empty, 1);
    chk("drain rx_count", rx_count, 0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("empty read rx_count", rx_count, 0);
    chk("empty read rd_empty", rd_empty, 1);
    chk("empty read sts", sts_vec(), 0);

    // Threshold at 4
    cfg_rx_thresh = 5'd4;
    for (int i = 0; i < 4; i++) begin
      fifo_wr   = 1'b1;
      fifo_data = 8'(8'h10 + i);
      step();
      chk($sformatf("thresh wr%0d irq_thresh", i), irq_thresh, (i == 3) ? 1 : 0);
    end
    fifo_wr = 1'b0;
    rd_en   = 1'b1;
    step();
    chk("thresh read irq_thresh", irq_thresh, 0);
    chk("thresh read rx_count", rx_count, 3);
    step();
    step();
    step();
    rd_en         = 1'b0;
    cfg_rx_thresh = '0;
    chk("thresh drained", rd_empty, 1);

    // Idle timeout of 10 cycles
    cfg_tout_val = 16'd10;
    fifo_wr      = 1'b1;
    fifo_data    = 8'h42;
    step();
    fifo_wr = 1'b0;
    chk("tout after write", irq_tout, 0);
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("tout idle%0d irq_tout", k), irq_tout, (k == 10) ? 1 : 0);
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("tout drained irq_tout", irq_tout, 0);
    chk("tout drained rd_empty", rd_empty, 1);
    cfg_tout_val = '0;

    // Flush keeps sticky flags
    error_ind = 2'b10;
    step();
    error_ind = 2'b00;
    step();
    chk("flush pre sts", sts_vec(), 3'b010);
    for (int i = 0; i < 5; i++) begin
      fifo_wr   = 1'b1;
      fifo_data = 8'(8'h60 + i);
      step();
    end
    chk("flush pre rx_count", rx_count, 5);
    cfg_rx_enable = 1'b0;
    fifo_data     = 8'h99;
    step();
    chk("flush rx_count", rx_count, 0);
    chk("flush rd_empty", rd_empty, 1);
    chk("flush sts kept", sts_vec(), 3'b010);
    cfg_rx_enable = 1'b1;
    fifo_wr       = 1'b0;
    step();
    chk("flush write ignored", rx_count, 0);

    // Asynchronous reset mid-write
    for (int i = 0; i < 3; i++) begin
      fifo_wr   = 1'b1;
      fifo_data = 8'(8'h70 + i);
      step();
    end
    chk("prereset rx_count", rx_count, 3);
    fifo_data = 8'h77;
    #2;
    reset = 1'b1;
    #1;
    chk("async reset rx_count", rx_count, 0);
    chk("async reset rd_empty", rd_empty, 1);
    chk("async reset fifo_aval", fifo_aval, 1);
    chk("async reset sts", sts_vec(), 0);
    chk("async reset irq", {irq_thresh, irq_tout}, 0);
    #2;
    reset   = 1'b0;
    fifo_wr = 1'b0;
    step();
    chk("post reset rx_count", rx_count, 0);
    fifo_wr   = 1'b1;
    fifo_data = 8'h5A;
    step();
    fifo_wr = 1'b0;
    chk("resume rx_count", rx_count, 1);
    chk("resume rd_data", rd_data, 8'h5A);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
